t_counter_sequencer: RTL and testbench

//   Controller for the WIDTH-bit T flip-flop counter bank on the DE2 board. Turns raw push-button and

---
 rtl/t_counter_sequencer.sv | 144 ++++++++++++++
 tb/tb_t_counter_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/t_counter_sequencer.sv
// Key-driven sequencer for an external WIDTH-bit T flip-flop counter bank: load strobe, toggle ticks, terminal detect.
// Build option CNT_CTRL_WRAP_EN: at terminal count reload the counter and keep running instead of stopping in DONE.
module t_counter_sequencer #(
  parameter int WIDTH    = 3,
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             key_start_n,
  input  logic             key_load_n,
  input  logic             sw_up,
  input  logic [WIDTH-1:0] sw_val,
  input  logic [WIDTH-1:0] sw_limit,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             ld,
  output logic [WIDTH-1:0] ld_val,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PAUSE = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           r_state, w_next;
  logic [2:0]       r_start_sync, r_load_sync;
  logic             w_start_p, w_load_p;
  logic [DIV_W-1:0] r_div, w_div_next;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_t, w_t_next;
  logic [WIDTH-1:0] r_ld_val, w_ld_val_next;
  logic [WIDTH-1:0] w_t_cnt;
  logic             r_ld, w_ld_next;
  logic             r_busy, r_done;
  logic             w_tick, w_term;

  // Bits [1:0] synchronise the raw key; bit [2] holds the previous synchronised level.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_start_sync <= '1;
      r_load_sync  <= '1;
    end else begin
      r_start_sync <= {r_start_sync[1:0], key_start_n};
      r_load_sync  <= {r_load_sync[1:0], key_load_n};
    end
  end

  assign w_start_p = r_start_sync[2] & ~r_start_sync[1];
  assign w_load_p  = r_load_sync[2] & ~r_load_sync[1];

  // Bit i toggles when every lower bit is at its carry (up) or borrow (down) value.
  always_comb begin
    logic v_carry;
    v_carry = 1'b1;
    w_t_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_t_cnt[i] = v_carry;
      v_carry    = v_carry & (sw_up ? q[i] : ~q[i]);
    end
  end

  always_comb begin
    w_next        = r_state;
    w_t_next      = '0;
    w_ld_next     = 1'b0;
    w_ld_val_next = r_ld_val;
    w_div_next    = r_div;
    w_tick        = (r_state == S_RUN) && (r_div == DIV_LAST);
    w_term        = sw_up ? (q == r_limit) : (q == '0);
    case (r_state)
      S_IDLE, S_PAUSE: begin
        if (w_load_p)       w_next = S_LOAD;
        else if (w_start_p) w_next = S_RUN;
      end
      S_LOAD: w_next = S_PAUSE;
      S_RUN: begin
        if (w_load_p)       w_next = S_LOAD;
        else if (w_start_p) w_next = S_PAUSE;
        else if (w_tick) begin
          if (!w_term) begin
            w_t_next = w_t_cnt;
          end else begin
`ifdef CNT_CTRL_WRAP_EN
            w_ld_next     = 1'b1;
            w_ld_val_next = sw_up ? '0 : r_limit;
`else
            w_next = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        if (w_load_p) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
    // A load request suppresses any tick in the same cycle, so t and ld never overlap.
    if (w_next == S_LOAD) begin
      w_ld_next     = 1'b1;
      w_ld_val_next = sw_val;
    end
    if (w_next == S_RUN)
      w_div_next = (r_state != S_RUN || w_tick) ? '0 : r_div + DIV_W'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_t      <= '0;
      r_ld     <= 1'b0;
      r_ld_val <= '0;
      r_limit  <= '0;
      r_div    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_t      <= w_t_next;
      r_ld     <= w_ld_next;
      r_ld_val <= w_ld_val_next;
      r_div    <= w_div_next;
      r_busy   <= (w_next == S_RUN);
      r_done   <= (w_next == S_DONE);
      if (w_next == S_LOAD) r_limit <= sw_limit;
    end
  end

  assign t      = r_t;
  assign ld     = r_ld;
  assign ld_val = r_ld_val;
  assign busy   = r_busy;
  assign done   = r_done;
  assign state  = r_state;

endmodule

// File: tb/tb_t_counter_sequencer.sv
// Bench for t_counter_sequencer: directed key scenarios plus random segments, timed event scoreboard.
module tb_t_counter_sequencer;

  localparam int W   = 3;
  localparam int TD  = 4;
  localparam int EW  = 2 * W + 1;
  localparam int MOD = 1 << W;
  localparam int ST_IDLE = 0, ST_LOAD = 1, ST_PAUSE = 2, ST_RUN = 3, ST_DONE = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_start_n, key_load_n, sw_up;
  logic [W-1:0] sw_val, sw_limit, q, t, ld_val;
  logic         ld, busy, done;
  logic [2:0]   state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc[$];

  int m_state, m_q, m_lim;
  bit m_up;

  logic [EW-1:0] mon_act, mon_exp;
  int            mon_c;

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  t_counter_sequencer #(.WIDTH(W), .TICK_DIV(TD), .DIV_W(3)) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .key_start_n(key_start_n), .key_load_n(key_load_n),
    .sw_up(sw_up), .sw_val(sw_val), .sw_limit(sw_limit), .q(q),
    .t(t), .ld(ld), .ld_val(ld_val), .busy(busy), .done(done), .state(state)
  );

  // external T flip-flop bank with parallel load
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= ld_val;
    else         q <= q ^ t;
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_state();
    chk("state", int'(state), m_state);
    chk("busy", int'(busy), int'(m_state == ST_RUN));
    chk("done", int'(done), int'(m_state == ST_DONE));
  endtask

  task automatic push_ev(input bit e_ld, input int e_val, input int e_t, input int at);
    exp_q.push_back({e_ld, W'(e_val), W'(e_t)});
    exp_cyc.push_back(at);
  endtask

  // scoreboard monitor: every ld or t pulse must match the next expected event and its cycle
  always @(negedge clk) begin
    if (t != '0 || ld) begin
      mon_act = {ld, (ld ? ld_val : {W{1'b0}}), t};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got ld=%0b val=%0d t=%b at cyc %0d, none expected",
                 ld, ld_val, t, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_c   = exp_cyc.pop_front();
        if (mon_act !== mon_exp || mon_c != cyc) begin
          bad++;
          $display("FAIL event: got ld=%0b val=%0d t=%b at cyc %0d, want ld=%0b val=%0d t=%b at cyc %0d",
                   mon_act[EW-1], mon_act[2*W-1:W], mon_act[W-1:0], cyc,
                   mon_exp[EW-1], mon_exp[2*W-1:W], mon_exp[W-1:0], mon_c);
        end
      end
    end
  end

  // driver tasks (entered and left at a negedge)
  task automatic press(input bit s, input bit l);
    key_start_n = ~s;
    key_load_n  = ~l;
    @(negedge clk);
    key_start_n = 1'b1;
    key_load_n  = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  // reference counting: each tick moves q by one step; toggles are the bits that change
  task automatic model_ticks(input int e, input int n);
    int nxt;
    bit term;
    for (int k = 1; k <= n; k++) begin
      if (m_state != ST_RUN) break;
      term = m_up ? (m_q == m_lim) : (m_q == 0);
      if (term) begin
`ifdef CNT_CTRL_WRAP_EN
        nxt = m_up ? 0 : m_lim;
        push_ev(1'b1, nxt, 0, e + TD * k);
        m_q = nxt;
`else
        m_state = ST_DONE;
`endif
      end else begin
        nxt = m_up ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
        push_ev(1'b0, 0, m_q ^ nxt, e + TD * k);
        m_q = nxt;
      end
    end
  endtask

  task automatic load_action(input int v, input int lim, input bit both);
    sw_val   = W'(v);
    sw_limit = W'(lim);
    push_ev(1'b1, v, 0, cyc + 3);
    press(both, 1'b1);
    chk("state_load", int'(state), ST_LOAD);
    @(negedge clk);
    m_state = ST_PAUSE;
    m_q     = v;
    m_lim   = lim;
    check_state();
  endtask

  task automatic start_run(input bit up);
    sw_up = up;
    m_up  = up;
    press(1'b1, 1'b0);
    if (m_state == ST_IDLE || m_state == ST_PAUSE) m_state = ST_RUN;
    check_state();
  endtask

  // stay w cycles after RUN entry, then press start (0), load (1) or both (2)
  task automatic run_for(input int w, input int action, input int v, input int lim);
    model_ticks(cyc, (w + 2) / TD);
    repeat (w) @(negedge clk);
    if (action == 0) begin
      press(1'b1, 1'b0);
      if (m_state == ST_RUN) m_state = ST_PAUSE;
      check_state();
    end else begin
      load_action(v, lim, action == 2);
    end
  endtask

  task automatic run_seg(input bit up, input int w, input int action, input int v, input int lim);
    start_run(up);
    run_for(w, action, v, lim);
  endtask

  initial begin
    key_start_n = 1'b1;
    key_load_n  = 1'b1;
    sw_up       = 1'b1;
    sw_val      = '0;
    sw_limit    = '0;
    m_state = ST_IDLE;
    m_q     = 0;
    m_lim   = 0;
    m_up    = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_t", int'(t), 0);
    chk("reset_ld", int'(ld), 0);
    chk("reset_ld_val", int'(ld_val), 0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // load 5 / limit 7, count up to terminal
    load_action(5, 7, 1'b0);
    run_seg(1'b1, 10, 0, 0, 0);
    // load 2, count down to zero
    load_action(2, 7, 1'b0);
    run_seg(1'b0, 10, 0, 0, 0);
    // start+load together exactly on a tick edge: load wins, no toggle
    load_action(3, 6, 1'b0);
    run_seg(1'b1, 1, 2, 1, 6);
    // pause two cycles before a tick, then resume with a fresh prescaler
    run_seg(1'b1, 3, 0, 0, 0);
    run_seg(1'b1, 6, 0, 0, 0);

    // reset while a tick is one cycle away
    start_run(1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_t", int'(t), 0);
    chk("rst_mid_ld", int'(ld), 0);
    chk("rst_mid_state", int'(state), ST_IDLE);
    m_state = ST_IDLE;
    m_q     = 0;
    m_lim   = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_state();

    for (int i = 0; i < 30; i++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op == 0)
        load_action($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), 1'b0);
      else
        run_seg(1'($urandom_range(0, 1)), $urandom_range(0, 24), $urandom_range(0, 2),
                $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
    end

    repeat (10) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
